// File: rtl/wb_pkg.sv
// Shared types for the writeback-port arbiter: default widths, FSM encoding
// and the pending-queue entry payload.
package wb_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned AW_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_STALL = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                  valid;
    logic [AW_DEFAULT-1:0] dst;
    logic [DW_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_pend_queue.sv
// Ordered compacting queue of long-latency results: push at tail, pop head,
// and squash every entry matching an address, all in one cycle.
module wb_pend_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_ent,
  input  logic                  pop,
  input  logic                  squash,
  input  logic [AW_DEFAULT-1:0] squash_dst,
  output wb_entry_t             head,
  output logic [CW-1:0]         count,
  output logic [CW-1:0]         count_nxt_c
);

  wb_entry_t   q     [DEPTH];
  wb_entry_t   q_nxt [DEPTH];
  logic        keep;
  int unsigned rank;

  // Survivors are packed toward slot 0 in their original order; push lands behind them.
  always_comb begin
    keep = 1'b0;
    rank = 0;
    for (int unsigned j = 0; j < DEPTH; j++) q_nxt[j] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      keep = q[i].valid && !(pop && i == 0) && !(squash && q[i].dst == squash_dst);
      if (keep) begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
          if (rank == j) q_nxt[j] = q[i];
        end
        rank = rank + 1;
      end
    end
    if (push && rank < DEPTH) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        if (rank == j) q_nxt[j] = push_ent;
      end
      rank = rank + 1;
    end
    count_nxt_c = CW'(rank);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= q_nxt[i];
      count <= count_nxt_c;
    end
  end

  assign head = q[0];

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback register-file port arbiter: pipeline writes win, long-latency
// results bypass or queue, with squash and starvation-driven stall requests.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DW           = DW_DEFAULT,
  parameter int unsigned AW           = AW_DEFAULT,
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_regwrite,
  input  logic                         wb_memtoreg,
  input  logic [DW-1:0]                wb_readdata,
  input  logic [DW-1:0]                wb_aluresult,
  input  logic [AW-1:0]                wb_dst,
  input  logic                         lu_valid,
  output logic                         lu_ready,
  input  logic [AW-1:0]                lu_dst,
  input  logic [DW-1:0]                lu_data,
  output logic                         rf_we,
  output logic [AW-1:0]                rf_waddr,
  output logic [DW-1:0]                rf_wdata,
  output logic                         pipe_stall,
  output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  wb_state_e     state, state_nxt;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic          pw, lacc, drain, bypass, enq;
  wb_entry_t     head, push_ent;
  logic [CW-1:0] cnt_nxt;

  assign pw       = wb_regwrite && (wb_dst != '0);
  assign lu_ready = (pend_cnt < CW'(DEPTH));
  assign lacc     = lu_valid && lu_ready;
  assign drain    = !pw && head.valid;
  assign bypass   = !pw && !head.valid && lacc && (lu_dst != '0);
  // A same-cycle pipeline write to the same register makes the result stale.
  assign enq      = lacc && (lu_dst != '0) && !bypass && !(pw && lu_dst == wb_dst);
  assign push_ent = '{valid: 1'b1, dst: AW_DEFAULT'(lu_dst), data: DW_DEFAULT'(lu_data)};

  wb_pend_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push        (enq),
    .push_ent    (push_ent),
    .pop         (drain),
    .squash      (pw),
    .squash_dst  (AW_DEFAULT'(wb_dst)),
    .head        (head),
    .count       (pend_cnt),
    .count_nxt_c (cnt_nxt)
  );

  // Zero-latency write-port mux.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pw) begin
        rf_we    = 1'b1;
        rf_waddr = wb_dst;
        rf_wdata = wb_memtoreg ? wb_readdata : wb_aluresult;
      end else if (head.valid) begin
        rf_we    = 1'b1;
        rf_waddr = AW'(head.dst);
        rf_wdata = DW'(head.data);
      end else if (bypass) begin
        rf_we    = 1'b1;
        rf_waddr = lu_dst;
        rf_wdata = lu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      pipe_stall <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      pipe_stall <= (state_nxt == ST_STALL);
    end
  end

  // Starvation tracking keyed off the post-update queue occupancy.
  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    case (state)
      ST_IDLE: begin
        if (cnt_nxt != '0) begin
          state_nxt  = ST_PEND;
          starve_nxt = '0;
        end
      end
      ST_PEND: begin
        if (cnt_nxt == '0) begin
          state_nxt  = ST_IDLE;
          starve_nxt = '0;
        end else if (drain) begin
          starve_nxt = '0;
        end else if (pw) begin
          starve_nxt = starve_cnt + SW'(1);
          if (starve_nxt >= SW'(STARVE_LIMIT)) state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (cnt_nxt == '0) begin
          state_nxt  = ST_IDLE;
          starve_nxt = '0;
        end else if (drain) begin
          state_nxt  = ST_PEND;
          starve_nxt = '0;
        end
      end
      default: begin
        state_nxt  = ST_IDLE;
        starve_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts
// each cycle's outputs; a negedge monitor pops and compares.
module tb_wb_port_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_regwrite, wb_memtoreg;
  logic [31:0] wb_readdata, wb_aluresult;
  logic [4:0]  wb_dst;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_dst;
  logic [31:0] lu_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [1:0]  pend_cnt;

  wb_port_arbiter #(.DW(32), .AW(5), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
    .wb_readdata(wb_readdata), .wb_aluresult(wb_aluresult), .wb_dst(wb_dst),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dst(lu_dst), .lu_data(lu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pipe_stall(pipe_stall), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    int          pend;
    logic        ready;
    logic        stall;
  } exp_t;

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } ment_t;

  exp_t  sb[$];
  ment_t mq[$];
  int    m_starve;
  logic  m_stall;
  logic  last_acc;
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: predict this cycle's outputs, then advance to the next cycle.
  task automatic step();
    exp_t  e;
    ment_t keep[$];
    ment_t ne;
    logic  pw, acc, was_busy, drained;
    e.ready  = (mq.size() < DEPTH);
    e.pend   = mq.size();
    e.stall  = m_stall;
    e.we     = 1'b0;
    e.addr   = '0;
    e.data   = '0;
    last_acc = 1'b0;
    ne.dst   = lu_dst;
    ne.data  = lu_data;
    if (rst) begin
      mq.delete();
      m_starve = 0;
      m_stall  = 1'b0;
    end else begin
      pw       = wb_regwrite && (wb_dst != 0);
      acc      = lu_valid && e.ready;
      last_acc = acc;
      was_busy = (mq.size() != 0);
      drained  = 1'b0;
      if (pw) begin
        e.we   = 1'b1;
        e.addr = wb_dst;
        e.data = wb_memtoreg ? wb_readdata : wb_aluresult;
        foreach (mq[i]) if (mq[i].dst != wb_dst) keep.push_back(mq[i]);
        mq = keep;
        if (acc && lu_dst != 0 && lu_dst != wb_dst) mq.push_back(ne);
      end else if (was_busy) begin
        e.we    = 1'b1;
        e.addr  = mq[0].dst;
        e.data  = mq[0].data;
        void'(mq.pop_front());
        drained = 1'b1;
        if (acc && lu_dst != 0) mq.push_back(ne);
      end else if (acc && lu_dst != 0) begin
        e.we   = 1'b1;
        e.addr = lu_dst;
        e.data = lu_data;
      end
      if (mq.size() == 0 || drained) begin
        m_starve = 0;
        m_stall  = 1'b0;
      end else if (pw && was_busy && !m_stall) begin
        m_starve++;
        if (m_starve >= LIMIT) m_stall = 1'b1;
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic we, input logic mtr, input logic [31:0] rd,
                        input logic [31:0] alu, input logic [4:0] dst);
    wb_regwrite = we; wb_memtoreg = mtr; wb_readdata = rd; wb_aluresult = alu; wb_dst = dst;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] dst, input logic [31:0] d);
    lu_valid = v; lu_dst = dst; lu_data = d;
  endtask

  // Monitor: the DUT presents a result every cycle.
  exp_t e_mon;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      e_mon = sb.pop_front();
      chk("rf_we",      64'(rf_we),      64'(e_mon.we));
      chk("rf_waddr",   64'(rf_waddr),   64'(e_mon.addr));
      chk("rf_wdata",   64'(rf_wdata),   64'(e_mon.data));
      chk("pend_cnt",   64'(pend_cnt),   64'(e_mon.pend));
      chk("lu_ready",   64'(lu_ready),   64'(e_mon.ready));
      chk("pipe_stall", 64'(pipe_stall), 64'(e_mon.stall));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1);
  end

  initial begin
    logic hold;
    m_starve = 0;
    m_stall  = 1'b0;
    rst = 1'b1;
    set_wb(0, 0, 0, 0, 0);
    set_lu(0, 0, 0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;

    // Pipeline-only writes
    set_wb(1, 1, 32'hDEADBEEF, 0, 8); step();
    set_wb(1, 0, 32'hDEADBEEF, 32'h5, 8); step();
    // Bypass
    set_wb(0, 0, 0, 0, 0); set_lu(1, 9, 32'h1234); step();
    set_lu(0, 0, 0); step();
    // Conflict, full queue, held third result, ordered drain
    set_wb(1, 0, 0, 32'h77, 8); set_lu(1, 10, 32'hA); step();
    set_lu(1, 11, 32'hB); step();
    set_lu(1, 12, 32'hC); step();
    set_wb(0, 0, 0, 0, 0); step();
    step();
    set_lu(0, 0, 0); step();
    step();
    // Squash queued entry and same-cycle result
    set_wb(1, 0, 0, 32'h9, 8); set_lu(1, 10, 32'h1); step();
    set_wb(1, 0, 0, 32'h2, 10); set_lu(1, 10, 32'h3); step();
    set_wb(0, 0, 0, 0, 0); set_lu(0, 0, 0); step();
    // Starvation then drain
    set_wb(1, 0, 0, 32'h11, 8); set_lu(1, 12, 32'h7); step();
    set_lu(0, 0, 0);
    for (int i = 0; i < 6; i++) step();
    set_wb(0, 0, 0, 0, 0); step();
    step();
    // Register 0
    set_wb(1, 0, 0, 32'h55, 0); step();
    set_wb(0, 0, 0, 0, 0); set_lu(1, 0, 32'h66); step();
    // Reset with two pending entries
    set_wb(1, 0, 0, 32'h1, 8); set_lu(1, 13, 32'hD); step();
    set_lu(1, 14, 32'hE); step();
    rst = 1'b1; set_lu(1, 15, 32'hF); step();
    rst = 1'b0; set_wb(0, 0, 0, 0, 0); set_lu(0, 0, 0); step();

    // Randomized traffic with alternating pipeline-write pressure
    hold = 1'b0;
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(79) == 0);
      wb_regwrite  = ($urandom_range(99) < (((n / 100) % 2 == 1) ? 85 : 45));
      wb_memtoreg  = 1'($urandom_range(1));
      wb_readdata  = $urandom;
      wb_aluresult = $urandom;
      wb_dst       = 5'($urandom_range(4));
      if (!hold) begin
        lu_valid = ($urandom_range(99) < 60);
        lu_dst   = 5'($urandom_range(4));
        lu_data  = $urandom;
      end
      step();
      hold = lu_valid && !last_acc;
    end

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port at the writeback stage.
- Shares the port between two sources:
  - the MEM/WB pipeline register outputs, which have absolute priority;
  - a long-latency unit (multiply/divide) result stream.
- Long-latency results that lose arbitration are held in a small ordered pending queue.
- Stale pending results are squashed, and a pipeline stall is requested when the pending queue starves.

Parameters:
- DW, 32, register data width
- AW, 5, register address width
- DEPTH, 2, pending-queue entries (>=1)
- STARVE_LIMIT, 4, consecutive blocked cycles before a stall is requested (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- wb_regwrite  in  1  MEM/WB RegWrite
- wb_memtoreg  in  1  MEM/WB MemToReg
- wb_readdata  in  DW  MEM/WB load data
- wb_aluresult  in  DW  MEM/WB ALU result
- wb_dst  in  AW  MEM/WB destination register
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  queue can accept a result
- lu_dst  in  AW  long-latency destination
- lu_data  in  DW  long-latency result
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- pipe_stall  out  1  request front-end bubble insertion
- pend_cnt  out  $clog2(DEPTH+1)  valid queue entries

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset:
  - queue empty, pend_cnt=0, starve_cnt=0, state IDLE, pipe_stall=0;
  - lu_ready=1 after reset; rf_we forced 0 while rst=1.
  - Reset asserted mid-operation discards all pending entries, with no write.
- Definitions:
  - pw = wb_regwrite && wb_dst!=0
  - lacc = lu_valid && lu_ready
- Write port is combinational from current state and inputs (zero latency). Priority, evaluated each cycle:
  - 1. If pw: rf_we=1, rf_waddr=wb_dst, rf_wdata = wb_memtoreg ? wb_readdata : wb_aluresult.
  - 2. Else if queue non-empty: write the oldest entry and pop it (a "drain").
  - 3. Else if lacc && lu_dst!=0: bypass-write lu_dst/lu_data directly. The queue is unchanged.
  - 4. Else rf_we=0; rf_waddr and rf_wdata = 0.
- lu_ready = (pend_cnt < DEPTH). It is state-only and does not depend on lu_valid.
- Accepted results with lu_dst==0 are consumed and discarded.
- Enqueue: lacc, lu_dst!=0, and the result is not bypassed → append at the tail.
  - A drain and an enqueue in the same cycle are legal.
  - A full queue never enqueues, because lu_ready=0.
- Squash on pw (the younger pipeline write wins):
  - every queue entry with dst==wb_dst is removed the same cycle, and the queue compacts in order;
  - an lacc result in the same cycle with lu_dst==wb_dst is discarded.
- pend_cnt always equals the number of valid entries after squash, drain and enqueue.
- Starvation FSM:
  - IDLE: queue empty. Go to PEND when an entry is enqueued.
  - PEND:
    - starve_cnt increments each cycle that pw=1.
    - Clear starve_cnt on any drain.
    - Queue empties → IDLE.
    - starve_cnt reaches STARVE_LIMIT → STALL.
  - STALL:
    - pipe_stall=1 (registered; asserted the cycle after the limit is reached).
    - Hold until a drain occurs. Then starve_cnt=0 and the FSM goes to PEND, or to IDLE if the queue is empty.
    - If squash empties the queue, go to IDLE and deassert.
- Writes to register 0 never assert rf_we.

Decomposition:
- Shared package wb_pkg:
  - DW and AW defaults;
  - the state encoding typedef (IDLE/PEND/STALL);
  - the queue entry struct {valid, dst, data}.
- One natural sub-module: wb_pend_queue, an ordered compacting queue with push, pop-head and squash-by-address, plus a count output. The FSM and the write-port mux stay in the top module.

Test Plan:
- Pipeline only: wb_regwrite=1, wb_dst=8, memtoreg=1, readdata=0xDEADBEEF → same cycle rf_we=1, rf_waddr=8, rf_wdata=0xDEADBEEF. Then memtoreg=0, aluresult=0x5 → rf_wdata=0x5.
- Bypass: wb_regwrite=0, lu_valid=1, dst=9, data=0x1234 → immediate write of r9=0x1234; pend_cnt stays 0.
- Conflict and full:
  - pw continuously to r8; lu results r10=0xA then r11=0xB → pend_cnt=2, lu_ready=0.
  - A third lu_valid is held without loss.
  - Drop pw → r10, then r11, are written in order on consecutive cycles.
- Squash: queue holds r10=0x1; pw writes r10=0x2 → pend_cnt becomes 0 and the last write to r10 is 0x2. Same-cycle lu_dst==wb_dst → discarded.
- Starvation (STARVE_LIMIT=4):
  - 1 entry pending, pw held high → pipe_stall rises in cycle 5 and stays high.
  - Drop pw → the entry drains; pipe_stall is 0 in the next cycle.
- Register 0 and reset: wb_dst=0 or lu_dst=0 → no rf_we. Assert rst with 2 pending entries → next cycle pend_cnt=0, lu_ready=1, pipe_stall=0, no write.
